// File: rtl/sync_debounce_multi.sv
// Multi-channel synchronizer with optional per-channel debounce and registered
// rise/fall pulses. One clock, synchronous active-high reset.
module sync_debounce_multi #(
   parameter int unsigned      WIDTH     = 1,
   parameter int unsigned      STAGES    = 2,
   parameter int unsigned      DEBOUNCE  = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   generate
      if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
         $error("sync_debounce_multi: STAGES must be in 2..4");
      end
   endgenerate

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] y_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) sync_q[k] <= RESET_VAL;
      end else begin
         sync_q[0] <= x;
         for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[STAGES-1];

   generate
      if (DEBOUNCE == 0) begin : g_bypass
         // y is the last sync flop; its next value is the flop feeding it.
         assign y      = s;
         assign y_next = sync_q[STAGES-2];
      end else begin : g_debounce
         localparam int CW = $clog2(DEBOUNCE + 1);
         localparam logic [CW-1:0] TC = CW'(DEBOUNCE - 1);

         logic [CW-1:0] cnt_q [WIDTH];

         always_comb begin
            y_next = y;
            for (int i = 0; i < WIDTH; i++) begin
               if (s[i] != y[i] && cnt_q[i] == TC) y_next[i] = s[i];
            end
         end

         // The count only advances while s disagrees with y, so it never
         // exceeds TC; any agreement discards the partial run.
         always_ff @(posedge clk) begin
            if (reset) begin
               y <= RESET_VAL;
               for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            end else begin
               y <= y_next;
               for (int i = 0; i < WIDTH; i++) begin
                  if (s[i] == y[i] || cnt_q[i] == TC) cnt_q[i] <= '0;
                  else                                cnt_q[i] <= cnt_q[i] + CW'(1);
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         rise <= '0;
         fall <= '0;
      end else begin
         rise <= y_next & ~y;
         fall <= ~y_next & y;
      end
   end

endmodule

// File: tb/tb_sync_debounce_multi.sv
// Bench for sync_debounce_multi: several parameterisations side by side,
// directed scenarios plus random traffic against a windowed reference model.
module tb_sync_debounce_multi;

   localparam int ND = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [ND];
   logic [3:0] xa  [ND];
   logic [3:0] ya  [ND];
   logic [3:0] ra  [ND];
   logic [3:0] fa  [ND];

   int n_pass  = 0;
   int n_total = 0;

   logic       y0, r0, f0, y1, r1, f1, y3, r3, f3;
   logic [3:0] y2, r2, f2, y4, r4, f4;
   logic [1:0] y5, r5, f5;

   sync_debounce_multi #(.WIDTH(1), .STAGES(2), .DEBOUNCE(0), .RESET_VAL(1'b0)) u_d0 (
      .clk(clk), .reset(rst[0]), .x(xa[0][0]), .y(y0), .rise(r0), .fall(f0));
   sync_debounce_multi #(.WIDTH(1), .STAGES(3), .DEBOUNCE(4), .RESET_VAL(1'b0)) u_d1 (
      .clk(clk), .reset(rst[1]), .x(xa[1][0]), .y(y1), .rise(r1), .fall(f1));
   sync_debounce_multi #(.WIDTH(4), .STAGES(2), .DEBOUNCE(0), .RESET_VAL(4'b0000)) u_d2 (
      .clk(clk), .reset(rst[2]), .x(xa[2]), .y(y2), .rise(r2), .fall(f2));
   sync_debounce_multi #(.WIDTH(1), .STAGES(2), .DEBOUNCE(0), .RESET_VAL(1'b1)) u_d3 (
      .clk(clk), .reset(rst[3]), .x(xa[3][0]), .y(y3), .rise(r3), .fall(f3));
   sync_debounce_multi #(.WIDTH(4), .STAGES(3), .DEBOUNCE(3), .RESET_VAL(4'b1010)) u_d4 (
      .clk(clk), .reset(rst[4]), .x(xa[4]), .y(y4), .rise(r4), .fall(f4));
   sync_debounce_multi #(.WIDTH(2), .STAGES(4), .DEBOUNCE(1), .RESET_VAL(2'b01)) u_d5 (
      .clk(clk), .reset(rst[5]), .x(xa[5][1:0]), .y(y5), .rise(r5), .fall(f5));

   assign ya[0] = {3'b000, y0};  assign ra[0] = {3'b000, r0};  assign fa[0] = {3'b000, f0};
   assign ya[1] = {3'b000, y1};  assign ra[1] = {3'b000, r1};  assign fa[1] = {3'b000, f1};
   assign ya[2] = y2;            assign ra[2] = r2;            assign fa[2] = f2;
   assign ya[3] = {3'b000, y3};  assign ra[3] = {3'b000, r3};  assign fa[3] = {3'b000, f3};
   assign ya[4] = y4;            assign ra[4] = r4;            assign fa[4] = f4;
   assign ya[5] = {2'b00, y5};   assign ra[5] = {2'b00, r5};   assign fa[5] = {2'b00, f5};

   function automatic int stg_of(int d);
      case (d)
         1, 4:    return 3;
         5:       return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int deb_of(int d);
      case (d)
         1:       return 4;
         4:       return 3;
         5:       return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int wid_of(int d);
      case (d)
         2, 4:    return 4;
         5:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic logic [3:0] rv_of(int d);
      case (d)
         3:       return 4'b0001;
         4:       return 4'b1010;
         5:       return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] mask_of(int d);
      return 4'((1 << wid_of(d)) - 1);
   endfunction

   // Reference model: history of sampled inputs and resets per edge. The
   // synchronized level after edge e is the input sampled STAGES-1 edges
   // earlier unless a reset fell inside that window. y moves to a new level
   // once the synchronized level has held that value for DEBOUNCE edges.
   int         n = -1;
   logic [3:0] xh [ND][64];
   logic       rh [ND][64];
   logic [3:0] ym [ND];
   logic [3:0] rm [ND];
   logic [3:0] fm [ND];

   function automatic logic s_at(int d, int ch, int e);
      logic [3:0] rv;
      logic [3:0] xv;
      rv = rv_of(d);
      for (int j = 0; j < stg_of(d); j++)
         if (e - j < 0 || rh[d][(e - j) % 64]) return rv[ch];
      xv = xh[d][(e - stg_of(d) + 1) % 64];
      return xv[ch];
   endfunction

   always @(posedge clk) begin
      logic old_v, new_v, v, ok;
      logic [3:0] rv;
      n = n + 1;
      for (int d = 0; d < ND; d++) begin
         xh[d][n % 64] = xa[d];
         rh[d][n % 64] = rst[d];
      end
      for (int d = 0; d < ND; d++) begin
         rv = rv_of(d);
         for (int ch = 0; ch < wid_of(d); ch++) begin
            old_v = ym[d][ch];
            if (rh[d][n % 64]) begin
               new_v = rv[ch];
            end else if (deb_of(d) == 0) begin
               new_v = s_at(d, ch, n);
            end else begin
               v  = s_at(d, ch, n - 1);
               ok = (v != old_v);
               for (int k = 2; k <= deb_of(d); k++)
                  if (s_at(d, ch, n - k) != v) ok = 1'b0;
               new_v = ok ? v : old_v;
            end
            ym[d][ch] = new_v;
            rm[d][ch] = !rh[d][n % 64] && new_v && !old_v;
            fm[d][ch] = !rh[d][n % 64] && !new_v && old_v;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] mk;
      logic [3:0] rv;
      for (int d = 0; d < ND; d++) begin
         rst[d] = 1'b1;
         xa[d]  = 4'($urandom);
      end
      repeat (3) tick();
      for (int d = 0; d < ND; d++) begin
         mk = mask_of(d);
         rv = rv_of(d);
         n_total++;
         if ((ya[d] & mk) !== (rv & mk))
            $display("FAIL reset_y dut%0d: got %b expected %b", d, ya[d] & mk, rv & mk);
         else n_pass++;
         n_total++;
         if (((ra[d] | fa[d]) & mk) !== 4'b0000)
            $display("FAIL reset_pulse dut%0d: rise %b fall %b expected 0", d, ra[d], fa[d]);
         else n_pass++;
      end
      for (int d = 0; d < ND; d++) begin
         rst[d] = 1'b0;
         xa[d]  = rv_of(d);
      end
      repeat (12) tick();
   endtask

   task automatic test_sync_basic();
      logic [2:0] exp_v [6];
      exp_v = '{3'b000, 3'b110, 3'b100, 3'b100, 3'b001, 3'b000};
      xa[0] = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 2) xa[0] = 4'b0000;
         n_total++;
         if ({y0, r0, f0} !== exp_v[k])
            $display("FAIL basic_sync step%0d: y/rise/fall %b expected %b", k, {y0, r0, f0}, exp_v[k]);
         else n_pass++;
      end
   endtask

   task automatic test_debounce();
      logic seen_y, seen_r;
      seen_y = 1'b0;
      seen_r = 1'b0;
      xa[1] = 4'b0001;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (k == 2) xa[1] = 4'b0000;
         seen_y |= y1;
         seen_r |= r1;
      end
      n_total++;
      if (seen_y !== 1'b0) $display("FAIL glitch_y: got y high, expected stays 0");
      else n_pass++;
      n_total++;
      if (seen_r !== 1'b0) $display("FAIL glitch_rise: got rise, expected none");
      else n_pass++;
      xa[1] = 4'b0001;
      for (int k = 1; k <= 10; k++) begin
         tick();
         n_total++;
         if ({y1, r1} !== {1'(k >= 7), 1'(k == 7)})
            $display("FAIL debounce_hold edge%0d: y/rise %b expected %b", k, {y1, r1}, {1'(k >= 7), 1'(k == 7)});
         else n_pass++;
      end
   endtask

   task automatic test_multi_channel();
      xa[2] = 4'b0101;
      repeat (4) tick();
      n_total++;
      if (y2 !== 4'b0101) $display("FAIL multi_pre: y %b expected 0101", y2);
      else n_pass++;
      xa[2] = 4'b1100;
      tick();
      n_total++;
      if ({y2, r2, f2} !== {4'b0101, 4'b0000, 4'b0000})
         $display("FAIL multi_wait: y %b rise %b fall %b expected 0101/0000/0000", y2, r2, f2);
      else n_pass++;
      tick();
      n_total++;
      if ({y2, r2, f2} !== {4'b1100, 4'b1000, 4'b0001})
         $display("FAIL multi_edge: y %b rise %b fall %b expected 1100/1000/0001", y2, r2, f2);
      else n_pass++;
      tick();
      n_total++;
      if ({r2, f2} !== 8'h00) $display("FAIL multi_after: rise %b fall %b expected 0", r2, f2);
      else n_pass++;
   endtask

   task automatic test_reset_val();
      rst[3] = 1'b1;
      xa[3]  = 4'b0001;
      repeat (2) tick();
      rst[3] = 1'b0;
      for (int k = 0; k < 20; k++) begin
         n_total++;
         if ({y3, r3, f3} !== 3'b100)
            $display("FAIL reset_val cyc%0d: y/rise/fall %b expected 100", k, {y3, r3, f3});
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_reset_mid_debounce();
      xa[1] = 4'b0000;
      repeat (14) tick();
      xa[1] = 4'b0001;
      repeat (5) tick();
      rst[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_total++;
         if (y1 !== 1'b0) $display("FAIL mid_reset_y cyc%0d: got %b expected 0", k, y1);
         else n_pass++;
      end
      rst[1] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_total++;
         if ({y1, r1} !== {1'(k >= 6), 1'(k == 6)})
            $display("FAIL mid_release edge%0d: y/rise %b expected %b", k, {y1, r1}, {1'(k >= 6), 1'(k == 6)});
         else n_pass++;
      end
   endtask

   task automatic test_toggle();
      logic prev_y, ey, er, ef;
      prev_y = 1'b0;
      for (int k = 0; k < 14; k++) begin
         xa[0] = (k < 10) ? {3'b000, 1'(k % 2 == 0)} : 4'b0000;
         tick();
         ey = (k >= 1 && k - 1 < 10) ? 1'((k - 1) % 2 == 0) : 1'b0;
         er = ey & ~prev_y;
         ef = ~ey & prev_y;
         prev_y = ey;
         n_total++;
         if ({y0, r0, f0} !== {ey, er, ef})
            $display("FAIL toggle step%0d: y/rise/fall %b expected %b", k, {y0, r0, f0}, {ey, er, ef});
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [3:0] mk;
      for (int c = 0; c < 600; c++) begin
         for (int d = 0; d < ND; d++) begin
            rst[d] = ($urandom_range(0, 49) == 0);
            for (int ch = 0; ch < wid_of(d); ch++)
               if ($urandom_range(0, 3) == 0) xa[d][ch] = ~xa[d][ch];
         end
         tick();
         for (int d = 0; d < ND; d++) begin
            mk = mask_of(d);
            n_total++;
            if ({ya[d] & mk, ra[d] & mk, fa[d] & mk} !== {ym[d] & mk, rm[d] & mk, fm[d] & mk})
               $display("FAIL random dut%0d cyc%0d: y %b rise %b fall %b expected y %b rise %b fall %b",
                        d, c, ya[d] & mk, ra[d] & mk, fa[d] & mk, ym[d] & mk, rm[d] & mk, fm[d] & mk);
            else n_pass++;
            n_total++;
            if ((ra[d] & fa[d]) !== 4'b0000)
               $display("FAIL random_coincident dut%0d cyc%0d: rise&fall %b expected 0000", d, c, ra[d] & fa[d]);
            else n_pass++;
         end
      end
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         rst[d] = 1'b1;
         xa[d]  = rv_of(d);
         ym[d]  = rv_of(d);
         rm[d]  = 4'b0000;
         fm[d]  = 4'b0000;
      end
      test_reset();
      test_sync_basic();
      test_debounce();
      test_multi_channel();
      test_reset_val();
      test_reset_mid_debounce();
      test_toggle();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sync_debounce_multi.md
Name: sync_debounce_multi

Overview:
- Parametrised successor to the team's single-bit two-flop synchronizer.
- Brings WIDTH independent asynchronous inputs into the clk domain through a configurable-depth flop chain.
- Optionally debounces each synchronized channel with a per-channel stability counter.
- Emits one-cycle rising and falling edge pulses per channel. Used for switches, buttons and slow cross-domain status lines feeding control FSMs.

Parameters:
- WIDTH, 1, number of independent channels.
- STAGES, 2, synchronizer flop depth per channel; legal range 2..4.
- DEBOUNCE, 0, consecutive stable cycles required before the output changes; 0 bypasses the debounce stage.
- RESET_VAL, '0, WIDTH-bit value loaded into every sync flop and y on reset.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- x  input  WIDTH  asynchronous inputs, one bit per channel.
- y  output  WIDTH  synchronized, debounced level per channel.
- rise  output  WIDTH  one-cycle pulse when y[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when y[i] goes 1->0.

Behaviour:
- Reset: the one clock and synchronous active-high reset are fixed. With reset high at a rising clk edge:
  - all sync flops and y load RESET_VAL;
  - all debounce counters load 0;
  - rise and fall load 0.
- Reset dominates all other activity, including a reset asserted mid-debounce; any partial count is discarded.
- Sync chain, per channel: sync[0] <= x[i]; sync[k] <= sync[k-1]. Let s = sync[STAGES-1].
- DEBOUNCE=0: y[i] is the register s itself. A change on x meeting setup before edge 0 appears on y after edge STAGES-1, i.e. STAGES edges of latency counting edge 0.
- DEBOUNCE>0, per-channel counter of width $clog2(DEBOUNCE+1):
  - s == y: counter <= 0.
  - s != y and counter < DEBOUNCE-1: counter <= counter+1.
  - s != y and counter == DEBOUNCE-1: y <= s, counter <= 0.
  - Net latency from input change to y change is STAGES+DEBOUNCE edges.
  - Any return of s to y before the threshold clears the count, so a pulse on s shorter than DEBOUNCE cycles never reaches y.
- Edges: rise and fall are registered. rise[i] is 1 in exactly the cycle in which y[i] first shows its new value 1 (computed from y_next & ~y); fall is symmetric. Otherwise both are 0.
- rise[i] and fall[i] are never both 1.
- No pulses are generated by reset itself, including on the cycle after reset deasserts, whatever the value of RESET_VAL.
- Channels are fully independent; simultaneous changes on several channels produce simultaneous pulses.
- Rapid x toggling with DEBOUNCE=0 passes through: y follows s every cycle and may pulse rise and fall on alternate cycles.
- Counter saturation cannot occur; the count is bounded by DEBOUNCE-1.
- Elaboration error if STAGES<2 or STAGES>4.

Test Plan:
- WIDTH=1, STAGES=2, DEBOUNCE=0, RESET_VAL=0:
  - Pulse reset; x<=1 after edge 3 -> y=1 after edge 5, rise=1 for exactly that one cycle.
  - x<=0 two edges later -> y=0 two edges after that, fall=1 for one cycle.
- STAGES=3, DEBOUNCE=4: x high for 3 cycles then low -> y stays 0, rise never asserts. x held high -> y=1 exactly 7 edges after the change, single rise pulse.
- WIDTH=4, DEBOUNCE=0: x=4'b0101 then 4'b1100 -> rise=4'b1000 and fall=4'b0001 in the same cycle, other bits 0.
- RESET_VAL=1, x=1 at reset release -> y=1 immediately after reset, rise and fall stay 0 for 20 cycles.
- DEBOUNCE=4: x high, assert reset after 2 counted cycles, release with x still high -> y=0 during reset. y rises only STAGES+4 edges after release, not earlier.
- DEBOUNCE=0: toggle x every cycle for 10 cycles -> y toggles each cycle after STAGES latency, rise and fall alternate, never coincident.
